// File: rtl/glitchcore_wb_pkg.sv
// Shared types and constants for the glitchcore Wishbone host and its register map.
// Imported by the host RTL and by benches that model the glitchcore slave.
package glitchcore_wb_pkg;

   localparam int GC_ADDR_W  = 32;
   localparam int GC_DATA_W  = 32;
   localparam int GC_TIMEOUT = 16;
   localparam int GC_TIMER_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } host_state_e;

   // glitchcore register map: control/config pairs per functional block
   localparam logic [31:0] GC_ARM_CTRL_ADR   = 32'h0000_0010;
   localparam logic [31:0] GC_ARM_CFG_ADR    = 32'h0000_0014;
   localparam logic [31:0] GC_TRIG_CTRL_ADR  = 32'h0000_0020;
   localparam logic [31:0] GC_TRIG_CFG_ADR   = 32'h0000_0024;
   localparam logic [31:0] GC_PULSE_CTRL_ADR = 32'h0000_0030;
   localparam logic [31:0] GC_PULSE_CFG_ADR  = 32'h0000_0034;

   function automatic logic gc_is_mapped(input logic [31:0] adr);
      logic hit;
      case (adr)
         GC_ARM_CTRL_ADR, GC_ARM_CFG_ADR,
         GC_TRIG_CTRL_ADR, GC_TRIG_CFG_ADR,
         GC_PULSE_CTRL_ADR, GC_PULSE_CFG_ADR: hit = 1'b1;
         default:                             hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/glitchcore_wb_host.sv
// Wishbone classic initiator: one host command becomes one bounded bus cycle and one response.
// A saturating 8-bit timer aborts cycles to a silent slave and reports rsp_err.
module glitchcore_wb_host
   import glitchcore_wb_pkg::*;
#(
   parameter int ADDR_W  = GC_ADDR_W,
   parameter int DATA_W  = GC_DATA_W,
   parameter int TIMEOUT = GC_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [ADDR_W-1:0]   cmd_adr,
   input  logic [DATA_W-1:0]   cmd_dat,
   input  logic [DATA_W/8-1:0] cmd_sel,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_dat,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic                wb_we_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam logic [GC_TIMER_W-1:0] TIMER_LAST = GC_TIMER_W'(TIMEOUT - 1);
   localparam logic [GC_TIMER_W-1:0] TIMER_MAX  = {GC_TIMER_W{1'b1}};

   host_state_e           state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]     rsp_dat_q, rsp_dat_d;
   logic [ADDR_W-1:0]     adr_q, adr_d;
   logic [DATA_W-1:0]     dat_q, dat_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic                  we_q, we_d;
   logic                  cyc_q, cyc_d;
   logic [GC_TIMER_W-1:0] timer_q, timer_d;

   logic accept_s;
   logic timeout_s;

   assign accept_s  = cmd_valid & cmd_ready_q;
   assign timeout_s = (timer_q == TIMER_LAST);

   // State and registered outputs; reset drops CYC/STB asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= {DATA_W{1'b0}};
         adr_q       <= {ADDR_W{1'b0}};
         dat_q       <= {DATA_W{1'b0}};
         sel_q       <= {SEL_W{1'b0}};
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         timer_q     <= {GC_TIMER_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         cyc_q       <= cyc_d;
         timer_q     <= timer_d;
      end
   end

   // Next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_BUS;
            else          state_d = ST_IDLE;
         end
         ST_BUS: begin
            if (wb_ack_i || timeout_s) state_d = ST_RESP;
            else                       state_d = ST_BUS;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
            else           state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; ack outside BUS is deliberately not looked at.
   always_comb begin
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      we_d        = we_q;
      cyc_d       = cyc_q;
      timer_d     = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               adr_d       = cmd_adr;
               dat_d       = cmd_dat;
               sel_d       = cmd_sel;
               we_d        = cmd_we;
               cyc_d       = 1'b1;
               timer_d     = {GC_TIMER_W{1'b0}};
               cmd_ready_d = 1'b0;
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         ST_BUS: begin
            // An ack arriving on the timeout edge still completes normally.
            if (wb_ack_i) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = we_q ? {DATA_W{1'b0}} : wb_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
            end else if (timeout_s) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = {DATA_W{1'b0}};
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
            end else if (timer_q != TIMER_MAX) begin
               timer_d = timer_q + {{(GC_TIMER_W-1){1'b0}}, 1'b1};
            end else begin
               timer_d = timer_q;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            cyc_d       = 1'b0;
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_dat   = rsp_dat_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_sel_o  = sel_q;
   assign wb_we_o   = we_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_glitchcore_wb_host.sv
// Bench for glitchcore_wb_host against a behavioural zero-wait glitchcore register slave.
module tb_glitchcore_wb_host;
   import glitchcore_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = 32'h0;
   logic [31:0] cmd_dat = 32'h0;
   logic [3:0]  cmd_sel = 4'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   logic        spur_ack = 1'b0;
   logic        slv_ack;
   logic [31:0] slv_regs [0:5];
   int          slv_idx;
   int          cyc_num = 0;
   logic [31:0] log_adr [$];
   int          log_cyc [$];

   int errors = 0;
   int checks = 0;

   glitchcore_wb_host #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
   );

   always #10 clk = ~clk;

   function automatic int reg_index(input logic [31:0] adr);
      case (adr)
         GC_ARM_CTRL_ADR:   return 0;
         GC_ARM_CFG_ADR:    return 1;
         GC_TRIG_CTRL_ADR:  return 2;
         GC_TRIG_CFG_ADR:   return 3;
         GC_PULSE_CTRL_ADR: return 4;
         GC_PULSE_CFG_ADR:  return 5;
         default:           return -1;
      endcase
   endfunction

   always_comb begin
      slv_idx  = reg_index(wb_adr_o);
      slv_ack  = 1'b0;
      wb_dat_i = 32'hDEAD_BEEF;
      if (slv_idx >= 0) begin
         wb_dat_i = slv_regs[slv_idx];
         slv_ack  = wb_cyc_o & wb_stb_o;
      end
   end
   assign wb_ack_i = slv_ack | spur_ack;

   always @(posedge clk) begin
      cyc_num <= cyc_num + 1;
      if (rst) begin
         for (int r = 0; r < 6; r++) slv_regs[r] <= 32'h0;
      end else if (slv_ack && wb_we_o) begin
         for (int b = 0; b < 4; b++)
            if (wb_sel_o[b]) slv_regs[slv_idx][8*b +: 8] <= wb_dat_o[8*b +: 8];
      end
      if (!rst && wb_cyc_o && wb_stb_o && wb_ack_i) begin
         log_adr.push_back(wb_adr_o);
         log_cyc.push_back(cyc_num);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int ncyc);
      int n;
      n = 0; ncyc = 0;
      while (!rsp_valid && n < 300) begin
         if (wb_cyc_o) ncyc++;
         @(negedge clk);
         n++;
      end
      chk("rsp_valid_wait", {31'h0, rsp_valid}, 32'h1);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        exp_err;
      logic [31:0] exp_dat;
      int          exp_cyc;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] b2b_adr [5];
   logic [31:0] b2b_dat [5];

   initial begin
      int          ncyc;
      int          k;
      logic [31:0] cap_adr, cap_dat;
      logic [3:0]  cap_sel;
      logic        cap_we;
      logic        stable;
      logic        saw_cyc;

      vecs[0] = '{1'b1, 32'h14, 32'h0000_0008, 4'hF, 1'b0, 32'h0,         1};
      vecs[1] = '{1'b0, 32'h14, 32'h0,         4'hF, 1'b0, 32'h0000_0008, 1};
      vecs[2] = '{1'b1, 32'h24, 32'hA5A5_1234, 4'h5, 1'b0, 32'h0,         1};
      vecs[3] = '{1'b0, 32'h24, 32'h0,         4'hF, 1'b0, 32'h00A5_0034, 1};
      vecs[4] = '{1'b0, 32'h40, 32'h0,         4'hF, 1'b1, 32'h0,         16};
      vecs[5] = '{1'b1, 32'h44, 32'h0000_1234, 4'hF, 1'b1, 32'h0,         16};
      vecs[6] = '{1'b1, 32'h30, 32'hFFFF_FFFF, 4'h8, 1'b0, 32'h0,         1};
      vecs[7] = '{1'b0, 32'h30, 32'h0,         4'hF, 1'b0, 32'hFF00_0000, 1};
      b2b_adr = '{32'h24, 32'h34, 32'h30, 32'h20, 32'h10};
      b2b_dat = '{32'h10, 32'h02, 32'h01, 32'h01, 32'h01};

      // Reset values while rst is held
      @(negedge clk); @(negedge clk);
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
      chk("rst_rsp_dat",   rsp_dat,            32'h0);
      chk("rst_cyc_stb",   {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
      chk("rst_adr",       wb_adr_o,           32'h0);
      chk("rst_dat_sel_we", {wb_dat_o[27:0], wb_sel_o} | {31'h0, wb_we_o}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a bus cycle drops CYC/STB without waiting for a clock
      issue(1'b0, 32'h40, 32'h0, 4'hF);
      @(negedge clk); @(negedge clk);
      chk("mid_bus_cyc", {31'h0, wb_cyc_o}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);

      // Table-driven single transactions
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         k = 0;
         while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
         cmd_we = vecs[i].we; cmd_adr = vecs[i].adr; cmd_dat = vecs[i].dat;
         cmd_sel = vecs[i].sel; cmd_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         cmd_valid = 1'b0;
         cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_sel = wb_sel_o; cap_we = wb_we_o;
         wait_rsp(ncyc);
         chk($sformatf("v%0d_err", i),  {31'h0, rsp_err}, {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d_dat", i),  rsp_dat, vecs[i].exp_dat);
         chk($sformatf("v%0d_ncyc", i), ncyc, vecs[i].exp_cyc);
         chk($sformatf("v%0d_adr", i),  cap_adr, vecs[i].adr);
         chk($sformatf("v%0d_wdat", i), cap_dat, vecs[i].dat);
         chk($sformatf("v%0d_sel_we", i), {27'h0, cap_sel, cap_we}, {27'h0, vecs[i].sel, vecs[i].we});
         @(negedge clk);
         chk($sformatf("v%0d_rsp_done", i), {31'h0, rsp_valid}, 32'h0);
      end

      // Back-to-back programming with cmd_valid held high
      log_adr.delete(); log_cyc.delete();
      k = 0;
      cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = b2b_adr[0]; cmd_dat = b2b_dat[0]; cmd_valid = 1'b1;
      for (int n = 0; n < 100 && k < 5; n++) begin
         if (cmd_ready) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (k < 5) begin cmd_adr = b2b_adr[k]; cmd_dat = b2b_dat[k]; end
            else cmd_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("b2b_count", log_adr.size(), 32'd5);
      if (log_adr.size() == 5) begin
         for (int i = 0; i < 5; i++) chk($sformatf("b2b_adr%0d", i), log_adr[i], b2b_adr[i]);
         for (int i = 1; i < 5; i++)
            chk($sformatf("b2b_gap%0d", i), {31'h0, (log_cyc[i] - log_cyc[i-1]) >= 3}, 32'h1);
      end
      issue(1'b0, 32'h24, 32'h0, 4'hF);
      wait_rsp(ncyc);
      chk("b2b_readback", rsp_dat, 32'h10);
      @(negedge clk);

      // Response backpressure with another command waiting
      rsp_ready = 1'b0;
      issue(1'b0, 32'h14, 32'h0, 4'hF);
      cmd_we = 1'b1; cmd_adr = 32'h10; cmd_dat = 32'h0; cmd_valid = 1'b1;
      wait_rsp(ncyc);
      stable = 1'b1; saw_cyc = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (!rsp_valid || rsp_dat !== 32'h8 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) stable = 1'b0;
         if (wb_cyc_o) saw_cyc = 1'b1;
      end
      chk("bp_rsp_stable", {31'h0, stable}, 32'h1);
      chk("bp_no_cyc", {31'h0, saw_cyc}, 32'h0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", {31'h0, rsp_valid}, 32'h0);
      chk("bp_release_ready", {31'h0, cmd_ready}, 32'h1);

      // Spurious acknowledge in IDLE
      spur_ack = 1'b1;
      @(negedge clk);
      spur_ack = 1'b0;
      chk("spur_idle_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("spur_idle_ready_cyc", {30'h0, cmd_ready, wb_cyc_o}, 32'h2);

      // Spurious acknowledge while a response is pending
      rsp_ready = 1'b0;
      issue(1'b0, 32'h14, 32'h0, 4'hF);
      wait_rsp(ncyc);
      spur_ack = 1'b1;
      @(negedge clk);
      spur_ack = 1'b0;
      @(negedge clk);
      chk("spur_resp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("spur_resp_dat", rsp_dat, 32'h8);
      chk("spur_resp_state", {29'h0, rsp_err, cmd_ready, wb_cyc_o}, 32'h0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("spur_resp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
